// File: rtl/fifo_pkg.sv
// Shared types, width helpers and threshold defaults for the single-clock FIFO.
package fifo_pkg;

  typedef enum logic {STD, FWFT} fifo_mode_e;

  localparam int AE_THRESH_DEF = 2;
  localparam int AF_MARGIN     = 2;

  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft_if.sv
// Push/pop handshake, data and status bundle for sync_fifo_fwft.
// master = producer/consumer side, slave = the FIFO itself.
interface sync_fifo_fwft_if #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 64
);
  localparam int CNT_W = fifo_pkg::cnt_w(DEPTH);

  logic                  flush;
  logic                  wen;
  logic [DATA_WIDTH-1:0] data_w;
  logic                  ren;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  rvalid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CNT_W-1:0]      count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wen, data_w, ren,
    input  data_r, rvalid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, wen, data_w, ren,
    output data_r, rvalid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ram.sv
// DEPTH x DATA_WIDTH storage: write lands at the clock edge, read is combinational.
// No reset; pointer logic in the parent decides which entries are meaningful.
module fifo_ram #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 64,
  parameter int PTR_W      = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [PTR_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO, any depth >= 2; standard mode reads in 1 cycle, FWFT shows the head word at once.
// Push rejected when full, pop rejected when empty (sticky overflow/underflow); flush beats wen/ren.
module sync_fifo_fwft #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 64,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = DEPTH - fifo_pkg::AF_MARGIN,
  parameter int AE_THRESH  = fifo_pkg::AE_THRESH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  sync_fifo_fwft_if.slave  bus
);
  import fifo_pkg::*;

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam fifo_mode_e MODE = (FWFT != 0) ? fifo_pkg::FWFT : fifo_pkg::STD;
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C   = CNT_W'(AE_THRESH);

  if (DEPTH < 2) begin : g_bad_depth
    $fatal(1, "sync_fifo_fwft: DEPTH must be >= 2");
  end
  if (AF_THRESH <= 0 || AF_THRESH > DEPTH) begin : g_bad_af
    $fatal(1, "sync_fifo_fwft: AF_THRESH out of range");
  end
  if (AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_bad_ae
    $fatal(1, "sync_fifo_fwft: AE_THRESH out of range");
  end

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  full_w, empty_w, push_ok, pop_ok;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Explicit wrap so non-power-of-2 depths never index past DEPTH-1.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_w  = (cnt_q == FULL_C);
  assign empty_w = (cnt_q == '0);
  assign push_ok = bus.wen & ~full_w  & ~bus.flush;
  assign pop_ok  = bus.ren & ~empty_w & ~bus.flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q | (bus.wen & full_w  & ~bus.flush);
    unf_d    = unf_q | (bus.ren & empty_w & ~bus.flush);
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_ok && !pop_ok) cnt_d = cnt_q + CNT_W'(1);
      if (pop_ok && !push_ok) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .PTR_W      (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr_q),
    .wdata (bus.data_w),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  if (MODE == fifo_pkg::STD) begin : g_std
    logic [DATA_WIDTH-1:0] data_r_q, data_r_d;
    logic                  rvalid_q, rvalid_d;

    always_comb begin
      data_r_d = data_r_q;
      rvalid_d = 1'b0;
      if (bus.flush) begin
        data_r_d = '0;
      end else if (pop_ok) begin
        data_r_d = ram_rdata;
        rvalid_d = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_r_q <= '0;
        rvalid_q <= 1'b0;
      end else begin
        data_r_q <= data_r_d;
        rvalid_q <= rvalid_d;
      end
    end

    assign bus.data_r = data_r_q;
    assign bus.rvalid = rvalid_q;
  end else begin : g_fwft
    assign bus.data_r = empty_w ? '0 : ram_rdata;
    assign bus.rvalid = ~empty_w;
  end

  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (cnt_q >= AF_C);
  assign bus.almost_empty = (cnt_q <= AE_C);
  assign bus.count        = cnt_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Drives a standard-mode and an FWFT-mode FIFO with identical traffic and
// checks both against one occupancy model plus a read-data scoreboard.
module tb_sync_fifo_fwft;
  localparam int DEPTH = 6;
  localparam int DW    = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_hold;
  logic          m_rvalid, m_ovf, m_unf;

  always #5 clk = ~clk;

  sync_fifo_fwft_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) ai ();
  sync_fifo_fwft_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) bi ();

  sync_fifo_fwft #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(0), .AF_THRESH(5), .AE_THRESH(1)) u_std (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ai)
  );

  sync_fifo_fwft #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(1), .AF_THRESH(5), .AE_THRESH(1)) u_fwft (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bi)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_q.delete();
    m_hold   = '0;
    m_rvalid = 1'b0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
  endtask

  task automatic check_all();
    int n;
    logic [DW-1:0] head;
    n    = q.size();
    head = (n != 0) ? q[0] : '0;
    check_eq("a_count",  32'(ai.count),        32'(n));
    check_eq("a_full",   32'(ai.full),         32'(n == DEPTH));
    check_eq("a_empty",  32'(ai.empty),        32'(n == 0));
    check_eq("a_afull",  32'(ai.almost_full),  32'(n >= 5));
    check_eq("a_aempty", 32'(ai.almost_empty), 32'(n <= 1));
    check_eq("a_ovf",    32'(ai.overflow),     32'(m_ovf));
    check_eq("a_unf",    32'(ai.underflow),    32'(m_unf));
    check_eq("a_rvalid", 32'(ai.rvalid),       32'(m_rvalid));
    check_eq("a_data_r", 32'(ai.data_r),       32'(m_hold));
    if (ai.rvalid === 1'b1) begin
      if (exp_q.size() == 0) check_eq("sb_extra_word", 32'(1), 32'(0));
      else                   check_eq("sb_order", 32'(ai.data_r), 32'(exp_q.pop_front()));
    end
    check_eq("b_count",  32'(bi.count),        32'(n));
    check_eq("b_empty",  32'(bi.empty),        32'(n == 0));
    check_eq("b_full",   32'(bi.full),         32'(n == DEPTH));
    check_eq("b_ovf",    32'(bi.overflow),     32'(m_ovf));
    check_eq("b_unf",    32'(bi.underflow),    32'(m_unf));
    check_eq("b_rvalid", 32'(bi.rvalid),       32'(n != 0));
    check_eq("b_data_r", 32'(bi.data_r),       32'(head));
  endtask

  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
    logic full_m, empty_m;
    ai.wen = w; ai.data_w = d; ai.ren = r; ai.flush = f;
    bi.wen = w; bi.data_w = d; bi.ren = r; bi.flush = f;
    full_m  = (q.size() == DEPTH);
    empty_m = (q.size() == 0);
    if (f) begin
      q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_hold = '0; m_rvalid = 1'b0;
    end else begin
      if (w && full_m)  m_ovf = 1'b1;
      if (r && empty_m) m_unf = 1'b1;
      m_rvalid = 1'b0;
      if (r && !empty_m) begin
        m_hold   = q.pop_front();
        m_rvalid = 1'b1;
        exp_q.push_back(m_hold);
      end
      if (w && !full_m) q.push_back(d);
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0;
    cycle_inputs_idle();
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;

    // Fill to full, then one rejected push.
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'h17, 1'b0, 1'b0);
    // Drain, then one rejected pop.
    for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Pointer wrap: 4 in/out, then 6 in/out.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Simultaneous push/pop at mid, full and empty occupancy.
    for (int i = 0; i < 3; i++)  cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h50 + i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)  cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'h6F, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)  cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'h70, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Head word visible in FWFT without ren.
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush with count=4, overflow set and a competing write.
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'h99, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    cycle_inputs_idle();
    #2;
    rst_n = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'hE1, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    check_eq("sb_leftover", 32'(exp_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic cycle_inputs_idle();
    ai.wen = 1'b0; ai.ren = 1'b0; ai.flush = 1'b0; ai.data_w = '0;
    bi.wen = 1'b0; bi.ren = 1'b0; bi.flush = 1'b0; bi.data_w = '0;
  endtask
endmodule

// File: doc/sync_fifo_fwft.md
Name: sync_fifo_fwft

Overview:
- Single-clock, parametrised successor to the dual-clock FIFO, for buffering inside one clock domain (e.g. ICB command/response staging ahead of the APB master FSM).
- Adds the following, none of which the dual-clock FIFO has:
  - arbitrary (non-power-of-2) depth;
  - selectable standard or first-word-fall-through (FWFT) read mode;
  - occupancy count and programmable almost-full/almost-empty flags;
  - synchronous flush;
  - sticky overflow/underflow error flags.

Parameters:
- DEPTH, 16: number of entries; any integer >= 2.
- DATA_WIDTH, 64: word width in bits.
- FWFT, 0: read mode. 0 = standard (registered read, 1-cycle latency); 1 = first-word-fall-through.
- AF_THRESH, DEPTH-2: almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 2: almost_empty asserts when count <= AE_THRESH.
- Derived constants:
  - PTR_W = max(1, $clog2(DEPTH)).
  - CNT_W = $clog2(DEPTH+1).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of contents and error flags.
- wen  in  1  push request.
- data_w  in  DATA_WIDTH  push data.
- ren  in  1  pop request.
- data_r  out  DATA_WIDTH  read data.
- rvalid  out  1  data_r holds a popped/head word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  CNT_W  current occupancy.
- overflow  out  1  sticky: a push was attempted while full.
- underflow  out  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset values (asynchronous, rst_n low):
  - pointers 0, count 0, data_r 0, rvalid 0;
  - empty 1, full 0, almost_full 0, overflow 0, underflow 0;
  - almost_empty 1, because count 0 <= AE_THRESH.
  - Storage array is not reset.
- Accept conditions: push_ok = wen & ~full & ~flush; pop_ok = ren & ~empty & ~flush.
- Flags are derived combinationally from the registered count, so each flag reflects the count after the previous edge.
- Pointer wrap: wr_ptr/rd_ptr increment modulo DEPTH, i.e. DEPTH-1 -> 0 explicitly; never rely on binary rollover.
- count update per cycle:
  - push_ok only: +1;
  - pop_ok only: -1;
  - both, or neither: unchanged.
- Simultaneous push and pop:
  - When full, the push is rejected even if ren is high. wen is accepted only when ~full.
  - When empty, the pop is rejected even if wen is high. No bypass.
- Write latency: a push at edge N makes empty fall after edge N, i.e. visible in cycle N+1.
- Standard mode (FWFT=0):
  - On pop_ok, data_r <= mem[rd_ptr] and rvalid <= 1 at the same edge.
  - Otherwise rvalid <= 0 and data_r holds its value.
- FWFT mode (FWFT=1):
  - data_r = mem[rd_ptr] combinationally when ~empty, else 0.
  - rvalid = ~empty.
  - ren acknowledges the displayed word; the next word appears in the following cycle.
- flush:
  - Clears pointers, count, overflow and underflow at the edge; empty is 1 afterwards.
  - Takes priority over wen and ren.
  - Standard mode: data_r <= 0 and rvalid <= 0.
- overflow is set on wen & full & ~flush; underflow is set on ren & empty & ~flush. Both clear only on flush or reset.
- FIFO order is strict; no word is lost or duplicated across pointer wrap.
- Reset asserted mid-operation clears all state immediately; contents are discarded.
- Elaboration checks (fatal on violation): DEPTH >= 2; 0 < AF_THRESH <= DEPTH; 0 <= AE_THRESH < DEPTH.

Decomposition:
- Package fifo_pkg:
  - fifo_mode_e enum {STD, FWFT};
  - clog2-based width function;
  - shared threshold-default constants.
- Sub-module fifo_ram:
  - DEPTH x DATA_WIDTH array;
  - synchronous write port, asynchronous read port;
  - no reset.
- Top level holds pointers, count, flags and the mode-dependent output logic.

Test Plan:
All scenarios use DEPTH=6, DATA_WIDTH=8, AF_THRESH=5, AE_THRESH=1.
1. Standard mode: push 0x11..0x16 -> full=1 and count=6 after the 6th edge; almost_full=1 from count=5. A 7th push sets overflow=1 and count stays 6.
2. Standard mode: pop 6 times -> data_r 0x11..0x16, each valid one cycle after ren with rvalid=1. empty=1 after the last pop. A 7th ren sets underflow=1.
3. Wrap: push 4, pop 4, push 6, pop 6 -> output order preserved across the pointer wrap 5 -> 0; count never exceeds 6.
4. Simultaneous: with count=3, wen=ren=1 for 10 cycles -> count stays 3 and output is ordered. With full, wen=ren=1 -> pop only, count=5. With empty, wen=ren=1 -> push only, count=1, no underflow.
5. FWFT=1: push 0xA5 -> in the next cycle data_r=0xA5 and rvalid=1 with no ren. ren=1 -> data_r=0 and empty=1 in the following cycle.
6. flush with count=4 and overflow=1, wen=1 in the same cycle -> count=0, empty=1, overflow=0, almost_empty=1, and the write is discarded. Assert rst_n low mid-burst -> all outputs return to their reset values asynchronously.
